// File: rtl/sgpio_initiator.sv
// SGPIO initiator: serializes activity/locate/fault per drive bay, 3 bits per bay, and
// collects the per-bay presence bit returned on sdatain during the same frame.
module sgpio_initiator #(
    parameter int NUM_DRIVES = 4,
    parameter int SCLK_HALF  = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DRIVES-1:0] activity,
    input  logic [NUM_DRIVES-1:0] locate,
    input  logic [NUM_DRIVES-1:0] fault,
    input  logic                  sgpio_sdatain,
    output logic                  sgpio_sclock,
    output logic                  sgpio_sload,
    output logic                  sgpio_sdataout,
    output logic [NUM_DRIVES-1:0] drive_present,
    output logic                  frame_done,
    output logic                  dbg_state
);

    localparam int F     = 3 * NUM_DRIVES;
    localparam int DIV_W = $clog2(SCLK_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [4:0]       K_LAST   = 5'(F - 1);
    localparam logic [F-1:0]     ONE      = {{(F-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  r_state;
    logic [4:0]              r_k;
    logic [DIV_W-1:0]        r_div;
    logic                    r_sclock;
    logic                    r_sload;
    logic                    r_sdo;
    logic                    r_done;
    logic [F-1:0]            r_shadow;
    logic [F-1:0]            r_rx;
    logic [NUM_DRIVES-1:0]   r_present;

    logic [F-1:0]            w_frame;
    logic [F-1:0]            w_rx_mask;
    logic [F-1:0]            w_next_mask;
    logic [F-1:0]            w_rx_next;
    logic                    w_next_bit;
    logic [NUM_DRIVES-1:0]   w_present;

    // Frame bit k = 3*d + j carries activity, locate, fault of bay d for j = 0, 1, 2.
    always_comb begin
        w_frame   = '0;
        w_present = '0;
        for (int d = 0; d < NUM_DRIVES; d++) begin
            w_frame[3*d]     = activity[d];
            w_frame[3*d + 1] = locate[d];
            w_frame[3*d + 2] = fault[d];
            w_present[d]     = r_rx[3*d];
        end
    end

    assign w_rx_mask   = ONE << r_k;
    assign w_next_mask = ONE << (r_k + 5'd1);
    assign w_rx_next   = (r_rx & ~w_rx_mask) | ({F{sgpio_sdatain}} & w_rx_mask);
    assign w_next_bit  = |(r_shadow & w_next_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_div     <= '0;
            r_sclock  <= 1'b0;
            r_sload   <= 1'b0;
            r_sdo     <= 1'b0;
            r_done    <= 1'b0;
            r_shadow  <= '0;
            r_rx      <= '0;
            r_present <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state  <= RUN;
                        r_shadow <= w_frame;
                        r_k      <= '0;
                        r_div    <= '0;
                        r_sclock <= 1'b0;
                        r_sload  <= 1'b1;
                        r_sdo    <= w_frame[0];
                    end
                end
                RUN: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div    <= '0;
                        r_sclock <= ~r_sclock;
                        if (!r_sclock) begin
                            r_rx <= w_rx_next;
                        end else if (r_k != K_LAST) begin
                            r_k     <= r_k + 5'd1;
                            r_sdo   <= w_next_bit;
                            r_sload <= 1'b0;
                        end else begin
                            // Last falling edge: publish presence and either chain or stop.
                            r_done    <= 1'b1;
                            r_present <= w_present;
                            r_k       <= '0;
                            if (en) begin
                                r_shadow <= w_frame;
                                r_sload  <= 1'b1;
                                r_sdo    <= w_frame[0];
                            end else begin
                                r_state <= IDLE;
                                r_sload <= 1'b0;
                                r_sdo   <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign sgpio_sclock   = r_sclock;
    assign sgpio_sload    = r_sload;
    assign sgpio_sdataout = r_sdo;
    assign drive_present  = r_present;
    assign frame_done     = r_done;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_sgpio_initiator.sv
// Randomized frame-level bench for sgpio_initiator with an expected-event queue
// consumed by an independent monitor on sclock rises and frame_done pulses.
module tb_sgpio_initiator;

  localparam int ND    = 4;
  localparam int H     = 4;
  localparam int F     = 3 * ND;
  localparam int BIT   = 2 * H;
  localparam int FRAME = F * BIT;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [ND-1:0] activity;
  logic [ND-1:0] locate;
  logic [ND-1:0] fault;
  logic          sdatain;
  logic          sclock;
  logic          sload;
  logic          sdo;
  logic [ND-1:0] drive_present;
  logic          frame_done;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0_rst;

  // {cycle[15:0], sload, sdataout} per sclock rise; {cycle[15:0], present} per frame end
  logic [17:0] exp_q[$];
  logic [19:0] pres_q[$];

  sgpio_initiator #(.NUM_DRIVES(ND), .SCLK_HALF(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .activity      (activity),
    .locate        (locate),
    .fault         (fault),
    .sgpio_sdatain (sdatain),
    .sgpio_sclock  (sclock),
    .sgpio_sload   (sload),
    .sgpio_sdataout(sdo),
    .drive_present (drive_present),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  logic          p_sclock = 1'b0;
  logic          p_sload  = 1'b0;
  logic          p_sdo    = 1'b0;
  logic [ND-1:0] p_dp     = '0;
  logic          rst_seen = 1'b0;
  logic [17:0]   m_bit;
  logic [19:0]   m_pres;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (sclock && !p_sclock) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sclock_rise", 1, 0);
      end else begin
        m_bit = exp_q.pop_front();
        check("rise_cycle", cyc, int'(m_bit[17:2]));
        check("sload_bit", int'(sload), int'(m_bit[1]));
        check("sdataout_bit", int'(sdo), int'(m_bit[0]));
      end
    end
    if (sclock && p_sclock)
      check("stable_while_sclock_high", int'({sload, sdo}), int'({p_sload, p_sdo}));
    if (frame_done) begin
      if (pres_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        m_pres = pres_q.pop_front();
        check("frame_done_cycle", cyc, int'(m_pres[19:4]));
        check("drive_present", int'(drive_present), int'(m_pres[3:0]));
      end
    end
    if (!frame_done && !rst_seen && drive_present != p_dp)
      check("present_changed_midframe", int'(drive_present), int'(p_dp));
    p_sclock = sclock;
    p_sload  = sload;
    p_sdo    = sdo;
    p_dp     = drive_present;
  end

  // driver: called at the negedge just before the frame's start edge, returns at the
  // negedge just before its frame_done edge
  task automatic run_frame(input logic [ND-1:0] a, input logic [ND-1:0] l,
                           input logic [ND-1:0] f, input logic [F-1:0] rx,
                           input logic en_next);
    int            c0;
    logic [F-1:0]  bits;
    logic [ND-1:0] p;
    activity = a;
    locate   = l;
    fault    = f;
    en       = 1'b1;
    c0       = cyc;
    for (int k = 0; k < F; k++) begin
      case (k % 3)
        0:       bits[k] = a[k/3];
        1:       bits[k] = l[k/3];
        default: bits[k] = f[k/3];
      endcase
      exp_q.push_back({16'(c0 + BIT*k + H + 1), (k == 0), bits[k]});
    end
    for (int d = 0; d < ND; d++) p[d] = rx[3*d];
    pres_q.push_back({16'(c0 + FRAME + 1), p});
    for (int b = 0; b < F; b++) begin
      sdatain = rx[b];
      if (b == 4) begin
        activity = ~a;
        locate   = 4'($urandom_range(15, 0));
        fault    = 4'($urandom_range(15, 0));
      end
      if (b == 5) en = en_next;
      for (int i = 0; i < BIT; i++) begin
        @(negedge clk);
        if (b == 0 && i == 0) begin
          check("start_sload", int'(sload), 1);
          check("start_sdataout", int'(sdo), int'(bits[0]));
          check("start_sclock", int'(sclock), 0);
        end
      end
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_outputs", int'({sclock, sload, sdo}), 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    activity = '0;
    locate   = '0;
    fault    = '0;
    sdatain  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sclock", int'(sclock), 0);
    check("reset_sload", int'(sload), 0);
    check("reset_sdataout", int'(sdo), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_present", int'(drive_present), 0);
    rst = 1'b0;
    idle_check(4);

    run_frame(4'b0000, 4'b0000, 4'b0001, 12'b0010_0000_0001, 1'b1);
    run_frame(4'b1111, 4'b0000, 4'b0000, 12'($urandom), 1'b1);
    for (int n = 0; n < 3; n++)
      run_frame(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                4'($urandom_range(15, 0)), 12'($urandom), (n != 2));
    idle_check(20);

    run_frame(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), 12'b0000_0100_1000, 1'b0);
    idle_check(4);
    check("present_before_reset", int'(drive_present), 6);

    // frame aborted by reset during bit 7
    activity = 4'b0001;
    locate   = '0;
    fault    = '0;
    sdatain  = 1'b0;
    en       = 1'b1;
    c0_rst   = cyc;
    for (int k = 0; k < 7; k++)
      exp_q.push_back({16'(c0_rst + BIT*k + H + 1), (k == 0), (k == 0)});
    repeat (7*BIT + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", int'({sclock, sload, sdo, frame_done}), 0);
    check("abort_present", int'(drive_present), 0);
    rst = 1'b0;
    run_frame(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), 12'($urandom), 1'b0);
    idle_check(6);

    check("leftover_bit_events", exp_q.size(), 0);
    check("leftover_frame_events", pres_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
